// File: rtl/iob_uart16550_drv_pkg.sv
// Register map, LSR bit positions and sequencer state encoding shared by the
// 16550 UART IOb driver and its transfer engine.
package iob_uart16550_drv_pkg;

  localparam logic [2:0] RBR_THR = 3'd0;
  localparam logic [2:0] IER     = 3'd1;
  localparam logic [2:0] FCR     = 3'd2;
  localparam logic [2:0] LCR     = 3'd3;
  localparam logic [2:0] LSR     = 3'd5;

  localparam logic [7:0] LCR_DLAB = 8'h80;
  localparam logic [7:0] LCR_8N1  = 8'h03;

  localparam int LSR_DR   = 0;
  localparam int LSR_THRE = 5;

  typedef enum logic [3:0] {
    INIT_LCR1,
    INIT_DLL,
    INIT_DLM,
    INIT_LCR2,
    INIT_FCR,
    INIT_IER,
    POLL_REQ,
    POLL_WAIT,
    RX_REQ,
    RX_WAIT,
    TX_REQ
  } drv_state_e;

endpackage

// File: rtl/iob_master_xfer.sv
// Single-outstanding IOb initiator: places one byte on its lane, holds the
// request until the target accepts it and returns the read byte on rvalid.
module iob_master_xfer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                cmd_valid_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic                cmd_we_i,
  input  logic [7:0]          cmd_byte_i,
  output logic                accept_o,
  output logic                done_o,
  output logic [7:0]          rd_byte_o,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i
);

  logic       pending_q, pending_d;
  logic [1:0] lane_q, lane_d;
  logic [1:0] lane;

  assign lane = cmd_addr_i[1:0];

  // Bus fields are zero whenever no request is presented, so an idle or
  // reset initiator drives a clean all-zero bus.
  always_comb begin
    iob_avalid_o = cmd_valid_i & ~pending_q;
    iob_addr_o   = '0;
    iob_wdata_o  = '0;
    iob_wstrb_o  = '0;
    if (iob_avalid_o) begin
      iob_addr_o = cmd_addr_i;
      if (cmd_we_i) begin
        iob_wdata_o = DATA_W'(cmd_byte_i) << {lane, 3'b000};
        iob_wstrb_o = (DATA_W/8)'(1) << lane;
      end
    end
  end

  assign accept_o  = iob_avalid_o & iob_ready_i;
  assign done_o    = (accept_o & cmd_we_i) | (pending_q & iob_rvalid_i);
  assign rd_byte_o = iob_rdata_i[{lane_q, 3'b000} +: 8];

  always_comb begin
    pending_d = pending_q;
    lane_d    = lane_q;
    if (accept_o && !cmd_we_i) begin
      pending_d = 1'b1;
      lane_d    = lane;
    end else if (pending_q && iob_rvalid_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pending_q <= 1'b0;
      lane_q    <= 2'd0;
    end else begin
      pending_q <= pending_d;
      lane_q    <= lane_d;
    end
  end

endmodule

// File: rtl/iob_uart16550_driver.sv
// Programs a 16550 UART over IOb after reset, then polls LSR to move bytes
// between the UART FIFOs and a pair of valid/ready byte streams.
module iob_uart16550_driver #(
  parameter int         ADDR_W  = 5,
  parameter int         DATA_W  = 32,
  parameter logic [7:0] LCR_VAL = 8'h03,
  parameter logic [7:0] FCR_VAL = 8'h07
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic [15:0]         div_i,
  input  logic                restart_i,
  output logic                init_done_o,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  input  logic [7:0]          tx_data_i,
  input  logic                tx_valid_i,
  output logic                tx_ready_o,
  output logic [7:0]          rx_data_o,
  output logic                rx_valid_o,
  input  logic                rx_ready_i
);

  import iob_uart16550_drv_pkg::*;

  drv_state_e        state_q, state_d;
  logic              run_q;
  logic [15:0]       div_q, div_d;
  logic              init_done_q, init_done_d;
  logic              thre_q, thre_d;
  logic              rx_valid_q, rx_valid_d;
  logic [7:0]        rx_data_q, rx_data_d;

  logic              cmd_valid;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_we;
  logic [7:0]        cmd_byte;
  logic              accept;
  logic              done;
  logic [7:0]        rd_byte;
  logic              restart_now;

  assign restart_now = (state_q == POLL_REQ) && restart_i;

  iob_master_xfer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_xfer (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .cmd_valid_i  (cmd_valid),
    .cmd_addr_i   (cmd_addr),
    .cmd_we_i     (cmd_we),
    .cmd_byte_i   (cmd_byte),
    .accept_o     (accept),
    .done_o       (done),
    .rd_byte_o    (rd_byte),
    .iob_avalid_o (iob_avalid_o),
    .iob_addr_o   (iob_addr_o),
    .iob_wdata_o  (iob_wdata_o),
    .iob_wstrb_o  (iob_wstrb_o),
    .iob_ready_i  (iob_ready_i),
    .iob_rvalid_i (iob_rvalid_i),
    .iob_rdata_i  (iob_rdata_i)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= INIT_LCR1;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT_LCR1: if (accept) state_d = INIT_DLL;
      INIT_DLL:  if (accept) state_d = INIT_DLM;
      INIT_DLM:  if (accept) state_d = INIT_LCR2;
      INIT_LCR2: if (accept) state_d = INIT_FCR;
      INIT_FCR:  if (accept) state_d = INIT_IER;
      INIT_IER:  if (accept) state_d = POLL_REQ;
      POLL_REQ: begin
        if (restart_i)   state_d = INIT_LCR1;
        else if (accept) state_d = POLL_WAIT;
      end
      // A full RX holding register masks DR so the byte stays in the UART FIFO.
      POLL_WAIT: begin
        if (done) begin
          if (rd_byte[LSR_DR] && !rx_valid_q)        state_d = RX_REQ;
          else if (rd_byte[LSR_THRE] && tx_valid_i)  state_d = TX_REQ;
          else                                       state_d = POLL_REQ;
        end
      end
      RX_REQ:    if (accept) state_d = RX_WAIT;
      RX_WAIT: begin
        if (done) state_d = (thre_q && tx_valid_i) ? TX_REQ : POLL_REQ;
      end
      TX_REQ:    if (accept) state_d = POLL_REQ;
      default:   state_d = INIT_LCR1;
    endcase
  end

  // No request is raised in the first cycle out of reset, while the divisor
  // is still being captured.
  always_comb begin
    cmd_valid = run_q;
    cmd_we    = 1'b1;
    cmd_addr  = '0;
    cmd_byte  = 8'h00;
    case (state_q)
      INIT_LCR1: begin cmd_addr = ADDR_W'(LCR);     cmd_byte = LCR_DLAB | LCR_8N1; end
      INIT_DLL:  begin cmd_addr = ADDR_W'(RBR_THR); cmd_byte = div_q[7:0];         end
      INIT_DLM:  begin cmd_addr = ADDR_W'(IER);     cmd_byte = div_q[15:8];        end
      INIT_LCR2: begin cmd_addr = ADDR_W'(LCR);     cmd_byte = LCR_VAL;            end
      INIT_FCR:  begin cmd_addr = ADDR_W'(FCR);     cmd_byte = FCR_VAL;            end
      INIT_IER:  begin cmd_addr = ADDR_W'(IER);     cmd_byte = 8'h00;              end
      POLL_REQ: begin
        cmd_valid = run_q & ~restart_i;
        cmd_we    = 1'b0;
        cmd_addr  = ADDR_W'(LSR);
      end
      RX_REQ: begin
        cmd_we   = 1'b0;
        cmd_addr = ADDR_W'(RBR_THR);
      end
      TX_REQ:    begin cmd_addr = ADDR_W'(RBR_THR); cmd_byte = tx_data_i;          end
      default:   cmd_valid = 1'b0;
    endcase
  end

  assign tx_ready_o  = (state_q == TX_REQ) && accept;
  assign init_done_o = init_done_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;

  // A load only happens from RX_WAIT, which is entered only with the holding
  // register empty, so load and consume never coincide.
  always_comb begin
    div_d       = div_q;
    init_done_d = init_done_q;
    thre_d      = thre_q;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    if (!run_q || restart_now) div_d = div_i;
    if (restart_now)                         init_done_d = 1'b0;
    else if ((state_q == INIT_IER) && accept) init_done_d = 1'b1;
    if ((state_q == POLL_WAIT) && done) thre_d = rd_byte[LSR_THRE];
    if ((state_q == RX_WAIT) && done) begin
      rx_valid_d = 1'b1;
      rx_data_d  = rd_byte;
    end else if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      run_q       <= 1'b0;
      div_q       <= 16'h0000;
      init_done_q <= 1'b0;
      thre_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
    end else begin
      run_q       <= 1'b1;
      div_q       <= div_d;
      init_done_q <= init_done_d;
      thre_q      <= thre_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
    end
  end

endmodule

// File: tb/tb_iob_uart16550_driver.sv
// Directed bench for the 16550 UART IOb driver: a behavioural IOb target
// answers LSR/RBR reads from bench-controlled values and logs every request.
module tb_iob_uart16550_driver;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [15:0] div = 16'h001B;
  logic        restart = 1'b0;
  logic        init_done;
  logic        iob_avalid;
  logic [4:0]  iob_addr;
  logic [31:0] iob_wdata;
  logic [3:0]  iob_wstrb;
  logic        iob_ready = 1'b1;
  logic        iob_rvalid = 1'b0;
  logic [31:0] iob_rdata = 32'h0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b1;

  int total = 0;
  int bad = 0;

  // target model state
  logic [7:0]  lsr_val = 8'h00;
  logic [7:0]  rbr_val = 8'h00;
  logic        rv_pend = 1'b0;
  logic [31:0] rv_data = 32'h0;
  logic        rbr_acc = 1'b0;
  int          tx_pulses = 0;
  logic        stall_arm = 1'b0;
  logic        stall_watch = 1'b0;
  int          stall_left = 0;
  int          stall_stable = 0;
  int          stall_bad = 0;
  logic [40:0] stall_ref = '0;

  logic [4:0]  lg_addr [$];
  logic [31:0] lg_data [$];
  logic [3:0]  lg_strb [$];
  logic        lg_done [$];

  iob_uart16550_driver dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .div_i        (div),
    .restart_i    (restart),
    .init_done_o  (init_done),
    .iob_avalid_o (iob_avalid),
    .iob_addr_o   (iob_addr),
    .iob_wdata_o  (iob_wdata),
    .iob_wstrb_o  (iob_wstrb),
    .iob_ready_i  (iob_ready),
    .iob_rvalid_i (iob_rvalid),
    .iob_rdata_i  (iob_rdata),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rx_ready)
  );

  always #5 clk = ~clk;

  // IOb target: drives ready/rvalid on the falling edge, then logs each
  // request that will be accepted on the next rising edge. Reads return
  // rvalid one cycle after acceptance. An armed stall holds ready low for
  // five cycles on the first register-0 write and watches the held request.
  always @(negedge clk) begin
    if (arst) begin
      iob_rvalid = 1'b0;
      rv_pend    = 1'b0;
      iob_ready  = 1'b1;
      stall_left = 0;
    end else begin
      iob_rvalid = rv_pend;
      iob_rdata  = rv_data;
      rv_pend    = 1'b0;
      if (stall_arm && iob_avalid && iob_wstrb != 4'h0 && iob_addr == 5'd0) begin
        stall_arm   = 1'b0;
        stall_left  = 5;
        stall_watch = 1'b1;
        stall_ref   = {iob_addr, iob_wdata, iob_wstrb};
      end
      iob_ready = (stall_left == 0);
      #1;
      if (tx_ready) tx_pulses++;
      if (iob_avalid && stall_watch) begin
        if ({iob_addr, iob_wdata, iob_wstrb} === stall_ref) stall_stable++;
        else stall_bad++;
      end
      if (iob_avalid && iob_ready) begin
        lg_addr.push_back(iob_addr);
        lg_data.push_back(iob_wdata);
        lg_strb.push_back(iob_wstrb);
        lg_done.push_back(init_done);
        if (iob_wstrb == 4'h0) begin
          rv_pend = 1'b1;
          rv_data = (iob_addr == 5'd5) ? {16'h0, lsr_val, 8'h00} : {24'h0, rbr_val};
          if (iob_addr == 5'd0) rbr_acc = 1'b1;
        end
        stall_watch = 1'b0;
      end
      if (stall_left > 0) stall_left--;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [40:0] entry(input int i);
    if (i < 0 || i >= lg_addr.size()) return '1;
    return {lg_addr[i], lg_data[i], lg_strb[i]};
  endfunction

  function automatic int nth_write(input int n);
    int c = 0;
    for (int i = 0; i < lg_addr.size(); i++) begin
      if (lg_strb[i] != 4'h0) begin
        if (c == n) return i;
        c++;
      end
    end
    return -1;
  endfunction

  function automatic int count_writes();
    int c = 0;
    for (int i = 0; i < lg_strb.size(); i++) if (lg_strb[i] != 4'h0) c++;
    return c;
  endfunction

  function automatic int count_reads(input logic [4:0] a);
    int c = 0;
    for (int i = 0; i < lg_strb.size(); i++) if (lg_strb[i] == 4'h0 && lg_addr[i] == a) c++;
    return c;
  endfunction

  task automatic clear_log();
    lg_addr.delete();
    lg_data.delete();
    lg_strb.delete();
    lg_done.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [15:0] d);
    arst = 1'b1;
    div  = d;
    @(negedge clk);
    @(negedge clk);
    clear_log();
    tx_pulses = 0;
    arst = 1'b0;
    #2;
  endtask

  task automatic wait_init_done(input string name);
    logic ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (init_done) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL %s init_done got=0 exp=1 within 100 cycles", name); end
  endtask

  task automatic wait_tx_pulse(input string name);
    logic ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #2;
      if (tx_pulses > 0) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL %s tx_ready got=0 exp=1 within 60 cycles", name); end
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #2;
    total++;
    if (iob_avalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_avalid got=%0b exp=0", iob_avalid); end
    total++;
    if (init_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_init_done got=%0b exp=0", init_done); end
    total++;
    if ({iob_addr, iob_wdata, iob_wstrb, tx_ready, rx_valid, rx_data} !== 51'h0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got addr=%h wdata=%h wstrb=%h txr=%b rxv=%b rxd=%h exp all 0",
               iob_addr, iob_wdata, iob_wstrb, tx_ready, rx_valid, rx_data);
    end
  endtask

  task automatic test_init();
    logic [40:0] exp_w [6];
    exp_w = '{{5'd3, 32'h83000000, 4'h8}, {5'd0, 32'h0000001B, 4'h1}, {5'd1, 32'h00000000, 4'h2},
              {5'd3, 32'h03000000, 4'h8}, {5'd2, 32'h00070000, 4'h4}, {5'd1, 32'h00000000, 4'h2}};
    do_reset(16'h001B);
    @(posedge clk); #1;
    div = 16'hFFFF;
    wait_init_done("init");
    div = 16'h001B;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (entry(k) !== exp_w[k]) begin
        bad++;
        $display("[TB] FAIL init_wr%0d got=%h exp=%h", k, entry(k), exp_w[k]);
      end
    end
    total++;
    if (count_writes() != 6) begin bad++; $display("[TB] FAIL init_wr_count got=%0d exp=6", count_writes()); end
    total++;
    if (lg_done.size() < 6 || lg_done[5] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL init_done_early got=%0b exp=0 during IER write", (lg_done.size() < 6) ? 1'bx : lg_done[5]);
    end
  endtask

  task automatic test_stall();
    stall_stable = 0;
    stall_bad    = 0;
    stall_arm    = 1'b1;
    do_reset(16'h001B);
    wait_init_done("stall");
    total++;
    if (stall_stable != 6 || stall_bad != 0) begin
      bad++;
      $display("[TB] FAIL stall_hold got stable=%0d changed=%0d exp stable=6 changed=0", stall_stable, stall_bad);
    end
    total++;
    if (entry(1) !== {5'd0, 32'h0000001B, 4'h1} || count_writes() != 6) begin
      bad++;
      $display("[TB] FAIL stall_dll got=%h writes=%0d exp=%h writes=6", entry(1), count_writes(), {5'd0, 32'h1B, 4'h1});
    end
  endtask

  task automatic test_tx();
    wait_cycles(5);
    clear_log();
    tx_pulses = 0;
    lsr_val   = 8'h20;
    tx_data   = 8'h55;
    tx_valid  = 1'b1;
    wait_tx_pulse("tx");
    tx_data = 8'h00;
    lsr_val = 8'h00;
    wait_cycles(10);
    total++;
    if (count_writes() != 1 || entry(nth_write(0)) !== {5'd0, 32'h00000055, 4'h1}) begin
      bad++;
      $display("[TB] FAIL tx_thr got=%h writes=%0d exp=%h writes=1", entry(nth_write(0)), count_writes(), {5'd0, 32'h55, 4'h1});
    end
    total++;
    if (tx_pulses != 1) begin bad++; $display("[TB] FAIL tx_pulse_count got=%0d exp=1", tx_pulses); end

    clear_log();
    tx_pulses = 0;
    tx_data   = 8'h66;
    tx_valid  = 1'b1;
    wait_cycles(30);
    total++;
    if (count_writes() != 0 || tx_pulses != 0 || count_reads(5'd5) < 5) begin
      bad++;
      $display("[TB] FAIL tx_no_thre got writes=%0d pulses=%0d lsr_reads=%0d exp writes=0 pulses=0 lsr_reads>=5",
               count_writes(), tx_pulses, count_reads(5'd5));
    end
    lsr_val = 8'h20;
    wait_tx_pulse("tx_late");
    lsr_val = 8'h00;
    wait_cycles(10);
    total++;
    if (entry(nth_write(0)) !== {5'd0, 32'h00000066, 4'h1}) begin
      bad++;
      $display("[TB] FAIL tx_late_thr got=%h exp=%h", entry(nth_write(0)), {5'd0, 32'h66, 4'h1});
    end
  endtask

  task automatic test_rx();
    logic ok = 1'b0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    rbr_val  = 8'hA5;
    clear_log();
    lsr_val  = 8'h01;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #2;
      if (rx_valid) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || rx_data !== 8'hA5) begin
      bad++;
      $display("[TB] FAIL rx_byte got valid=%0b data=%h exp valid=1 data=a5", rx_valid, rx_data);
    end
    wait_cycles(3);
    clear_log();
    wait_cycles(40);
    total++;
    if (count_reads(5'd0) != 0 || count_writes() != 0 || count_reads(5'd5) < 5) begin
      bad++;
      $display("[TB] FAIL rx_full_hold got rbr_reads=%0d writes=%0d lsr_reads=%0d exp 0 0 >=5",
               count_reads(5'd0), count_writes(), count_reads(5'd5));
    end
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
      bad++;
      $display("[TB] FAIL rx_full_keep got valid=%0b data=%h exp valid=1 data=a5", rx_valid, rx_data);
    end
    rbr_val  = 8'h3C;
    rx_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #2;
      if (rx_valid && rx_data == 8'h3C) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL rx_next got data=%h exp=3c after consume", rx_data); end
    lsr_val = 8'h00;
    wait_cycles(10);
    total++;
    if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL rx_consumed got valid=%0b exp=0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    int w;
    rx_ready  = 1'b1;
    clear_log();
    tx_pulses = 0;
    rbr_val   = 8'h5A;
    tx_data   = 8'h77;
    tx_valid  = 1'b1;
    lsr_val   = 8'h21;
    wait_tx_pulse("rxtx");
    lsr_val = 8'h00;
    wait_cycles(10);
    w = nth_write(0);
    total++;
    if (entry(w) !== {5'd0, 32'h00000077, 4'h1}) begin
      bad++;
      $display("[TB] FAIL rxtx_thr got=%h exp=%h", entry(w), {5'd0, 32'h77, 4'h1});
    end
    total++;
    if (w < 2 || entry(w - 1) !== {5'd0, 32'h0, 4'h0} || entry(w - 2) !== {5'd5, 32'h0, 4'h0}) begin
      bad++;
      $display("[TB] FAIL rxtx_order got prev=%h prev2=%h exp prev=%h prev2=%h",
               entry(w - 1), entry(w - 2), {5'd0, 32'h0, 4'h0}, {5'd5, 32'h0, 4'h0});
    end
    total++;
    if (rx_data !== 8'h5A) begin bad++; $display("[TB] FAIL rxtx_rxdata got=%h exp=5a", rx_data); end
  endtask

  task automatic test_reset_mid();
    logic ok = 1'b0;
    rx_ready = 1'b0;
    rbr_val  = 8'hC3;
    rbr_acc  = 1'b0;
    lsr_val  = 8'h01;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #2;
      if (rbr_acc) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL mid_rbr got no RBR read exp one within 50 cycles"); end
    @(posedge clk); #1;
    arst = 1'b1;
    #1;
    total++;
    if ({iob_avalid, iob_addr, iob_wdata, iob_wstrb, init_done, tx_ready, rx_valid, rx_data} !== 53'h0) begin
      bad++;
      $display("[TB] FAIL mid_reset_outputs got av=%b addr=%h wd=%h ws=%h done=%b txr=%b rxv=%b rxd=%h exp all 0",
               iob_avalid, iob_addr, iob_wdata, iob_wstrb, init_done, tx_ready, rx_valid, rx_data);
    end
    lsr_val  = 8'h00;
    rx_ready = 1'b1;
    do_reset(16'h001B);
    wait_init_done("mid_replay");
    total++;
    if (entry(0) !== {5'd3, 32'h83000000, 4'h8} || entry(1) !== {5'd0, 32'h0000001B, 4'h1}) begin
      bad++;
      $display("[TB] FAIL mid_replay got=%h,%h exp=%h,%h", entry(0), entry(1),
               {5'd3, 32'h83000000, 4'h8}, {5'd0, 32'h1B, 4'h1});
    end
    total++;
    if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_rx_dropped got valid=%0b exp=0", rx_valid); end
  endtask

  task automatic test_restart();
    logic ok = 1'b0;
    wait_cycles(5);
    clear_log();
    div     = 16'h0001;
    restart = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      if (!init_done) begin ok = 1'b1; break; end
    end
    restart = 1'b0;
    div     = 16'h00FF;
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL restart_clear got init_done=1 exp=0 within 20 cycles"); end
    wait_init_done("restart");
    total++;
    if (entry(nth_write(0)) !== {5'd3, 32'h83000000, 4'h8} || entry(nth_write(1)) !== {5'd0, 32'h00000001, 4'h1}) begin
      bad++;
      $display("[TB] FAIL restart_dll got=%h,%h exp=%h,%h", entry(nth_write(0)), entry(nth_write(1)),
               {5'd3, 32'h83000000, 4'h8}, {5'd0, 32'h1, 4'h1});
    end
    total++;
    if (entry(nth_write(2)) !== {5'd1, 32'h00000000, 4'h2} || count_writes() != 6) begin
      bad++;
      $display("[TB] FAIL restart_dlm got=%h writes=%0d exp=%h writes=6", entry(nth_write(2)), count_writes(),
               {5'd1, 32'h0, 4'h2});
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_init();
    test_stall();
    test_tx();
    test_rx();
    test_back_to_back();
    test_reset_mid();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
